seq_pattern_detector: RTL and testbench

Parametrised, runtime-programmable Moore sequence detector. It is the successor to the fixed "1111" detector in the string-recognition datapath. It watches a qualified serial bit stream and flags every occurrence of a programmable pattern of 1..PAT_W bits, with selectable overlapping or non-overlapping matching. An optional saturating match counter is included. After reset it behaves as an overlapping all-ones detector of length PAT_W.

---
 rtl/seq_det_pkg.sv | 25 ++
 rtl/seq_pattern_detector_if.sv | 28 ++
 rtl/seq_det_sat_counter.sv | 34 +++
 rtl/seq_pattern_detector.sv | 101 ++++++++++
 tb/tb_seq_pattern_detector.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
package seq_det_pkg;

    localparam int unsigned MAX_PAT_W = 16;

    // After reset the detector acts as an overlapping all-ones detector.
    localparam logic [MAX_PAT_W-1:0] DEF_PATTERN = '1;
    localparam logic                 DEF_OVERLAP = 1'b1;

    // A length of 0 or anything beyond the physical width selects the full width.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned pat_w);
        return ((len == 0) || (len > pat_w)) ? pat_w : len;
    endfunction

    // Ones in the low 'len' positions; positions above the active length are ignored.
    function automatic logic [MAX_PAT_W-1:0] len_mask(input int unsigned len);
        logic [MAX_PAT_W-1:0] ones;
        ones = '1;
        if (len >= MAX_PAT_W) begin
            return ones;
        end
        return ~(ones << len);
    endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Configuration, serial stream and status signals of the sequence detector.
interface seq_pattern_detector_if #(
    parameter int PAT_W = 4,
    parameter int LEN_W = $clog2(PAT_W + 1),
    parameter int CNT_W = 8
);
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             seq_valid;
    logic             seq_in;
    logic             seq_out;
    logic             count_clr;
    logic [CNT_W-1:0] match_count;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output seq_valid, seq_in, count_clr,
        input  seq_out, match_count
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  seq_valid, seq_in, count_clr,
        output seq_out, match_count
    );
endinterface

// File: rtl/seq_det_sat_counter.sv
// Saturating event counter; a clear coinciding with an increment yields 1.
module seq_det_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins over hold, increment stops at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? CNT_W'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable Moore sequence detector (1..PAT_W bit pattern,
// overlapping or non-overlapping). The saturating match counter is present
// only when SEQDET_COUNT_EN is defined; otherwise match_count reads 0.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int LEN_W = $clog2(PAT_W + 1),
    parameter int CNT_W = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    seq_pattern_detector_if.slave  bus
);
    localparam logic [PAT_W-1:0] PAT_RST = DEF_PATTERN[PAT_W-1:0];
    localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(PAT_W);

    logic [PAT_W-1:0] pat_q,  pat_d;
    logic [LEN_W-1:0] len_q,  len_d;
    logic             ovl_q,  ovl_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             seq_out_q, seq_out_d;

    logic [PAT_W-1:0]     hist_n;
    logic [LEN_W-1:0]     fill_n;
    logic [MAX_PAT_W-1:0] mask;
    logic                 hit;
    logic                 match;

    // Candidate history/fill if the current bit were accepted, and whether it completes the pattern.
    always_comb begin
        hist_n = {hist_q[PAT_W-2:0], bus.seq_in};
        fill_n = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
        mask   = len_mask(32'(len_q));
        hit    = (fill_n == len_q) &&
                 ((MAX_PAT_W'(hist_n) & mask) == (MAX_PAT_W'(pat_q) & mask));
    end

    // Next state: cfg_load flushes history and discards the coincident bit; gaps hold everything.
    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        seq_out_d = seq_out_q;
        match     = 1'b0;
        if (bus.cfg_load) begin
            pat_d     = bus.cfg_pattern;
            len_d     = LEN_W'(clamp_len(32'(bus.cfg_len), PAT_W));
            ovl_d     = bus.cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
            seq_out_d = 1'b0;
        end else if (bus.seq_valid) begin
            match     = hit;
            hist_d    = hist_n;
            seq_out_d = hit;
            fill_d    = (hit && !ovl_q) ? '0 : fill_n;
        end
    end

    // Configuration and detector registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pat_q     <= PAT_RST;
            len_q     <= LEN_RST;
            ovl_q     <= DEF_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            seq_out_q <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            seq_out_q <= seq_out_d;
        end
    end

    assign bus.seq_out = seq_out_q;

`ifdef SEQDET_COUNT_EN
    seq_det_sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clock (clock),
        .reset (reset),
        .inc   (match),
        .clr   (bus.count_clr),
        .count (bus.match_count)
    );
`else
    logic unused_cnt;
    assign unused_cnt      = match & bus.count_clr;
    assign bus.match_count = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Randomized + directed bench for seq_pattern_detector against a bit-queue reference model.
module tb_seq_pattern_detector;
    localparam int PAT_W = 4;
    localparam int LEN_W = $clog2(PAT_W + 1);
`ifdef SEQDET_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    seq_pattern_detector_if #(.PAT_W(PAT_W), .CNT_W(8)) bus ();
    seq_pattern_detector_if #(.PAT_W(PAT_W), .CNT_W(2)) bus2 ();

    assign bus2.cfg_load    = bus.cfg_load;
    assign bus2.cfg_pattern = bus.cfg_pattern;
    assign bus2.cfg_len     = bus.cfg_len;
    assign bus2.cfg_overlap = bus.cfg_overlap;
    assign bus2.seq_valid   = bus.seq_valid;
    assign bus2.seq_in      = bus.seq_in;
    assign bus2.count_clr   = bus.count_clr;

    seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: bits received since the last flush, newest at the back.
    bit              m_q[$];
    bit [PAT_W-1:0]  m_pat;
    int              m_len;
    bit              m_ovl;
    bit              m_out;
    int              m_cnt8;
    int              m_cnt2;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int cexp(input int n);
        return CNT_EN ? n : 0;
    endfunction

    function automatic int sat_next(input int cnt, input bit clr, input bit m, input int maxv);
        if (clr) return m ? 1 : 0;
        if (m && cnt < maxv) return cnt + 1;
        return cnt;
    endfunction

    task automatic model_update(input bit rst, input bit load, input bit valid, input bit din,
                                input bit clr, input bit [PAT_W-1:0] pat, input int len, input bit ovl);
        bit m;
        m = 1'b0;
        if (rst) begin
            m_pat = '1; m_len = PAT_W; m_ovl = 1'b1; m_out = 1'b0;
            m_q.delete(); m_cnt8 = 0; m_cnt2 = 0;
            return;
        end
        if (load) begin
            m_pat = pat;
            m_len = (len == 0 || len > PAT_W) ? PAT_W : len;
            m_ovl = ovl;
            m_q.delete();
            m_out = 1'b0;
        end else if (valid) begin
            m_q.push_back(din);
            if (m_q.size() > 16) void'(m_q.pop_front());
            if (m_q.size() >= m_len) begin
                m = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (m_q[m_q.size() - 1 - i] != m_pat[i]) m = 1'b0;
            end
            m_out = m;
            if (m && !m_ovl) m_q.delete();
        end
        m_cnt8 = sat_next(m_cnt8, clr, m, 255);
        m_cnt2 = sat_next(m_cnt2, clr, m, 3);
    endtask

    task automatic step(input bit rst, input bit load, input bit valid, input bit din, input bit clr,
                        input bit [PAT_W-1:0] pat = '0, input int len = 0, input bit ovl = 1'b0);
        reset           = rst;
        bus.cfg_load    = load;
        bus.cfg_pattern = pat;
        bus.cfg_len     = LEN_W'(len);
        bus.cfg_overlap = ovl;
        bus.seq_valid   = valid;
        bus.seq_in      = din;
        bus.count_clr   = clr;
        @(posedge clock);
        model_update(rst, load, valid, din, clr, pat, len, ovl);
        #1;
        check_val("seq_out",   32'(bus.seq_out),      32'(m_out));
        check_val("count8",    32'(bus.match_count),  cexp(m_cnt8));
        check_val("count2",    32'(bus2.match_count), cexp(m_cnt2));
        check_val("seq_out2",  32'(bus2.seq_out),     32'(m_out));
    endtask

    task automatic bits(input string s);
        for (int i = 0; i < s.len(); i++) step(0, 0, 1, s[i] == "1", 0);
    endtask

    task automatic load(input bit [PAT_W-1:0] pat, input int len, input bit ovl);
        step(0, 1, 1'b0, 1'b0, 1'b1, pat, len, ovl);
    endtask

    initial begin
        reset = 1'b1;
        bus.cfg_load = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
        bus.seq_valid = 0; bus.seq_in = 0; bus.count_clr = 0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check_val("rst_out", 32'(bus.seq_out), 0);
        check_val("rst_cnt", 32'(bus.match_count), 0);

        // Default overlapping all-ones detector.
        bits("111");
        check_val("def_no_early", 32'(bus.seq_out), 0);
        bits("1");
        check_val("def_bit4", 32'(bus.seq_out), 1);
        bits("11");
        check_val("def_bit6", 32'(bus.seq_out), 1);
        bits("0");
        check_val("def_bit7", 32'(bus.seq_out), 0);
        check_val("def_cnt", 32'(bus.match_count), cexp(3));

        // 1010 non-overlapping then overlapping.
        load(4'b1010, 4, 1'b0);
        bits("1010101010");
        check_val("nonovl_cnt", 32'(bus.match_count), cexp(2));
        load(4'b1010, 4, 1'b1);
        bits("1010101010");
        check_val("ovl_cnt", 32'(bus.match_count), cexp(4));

        // Short length with masked upper bits, then clamped length 0.
        load(4'b1101, 3, 1'b1);
        bits("010");
        check_val("len3_early", 32'(bus.seq_out), 0);
        bits("1");
        check_val("len3_match", 32'(bus.seq_out), 1);
        check_val("len3_cnt", 32'(bus.match_count), cexp(1));
        load(4'b1111, 0, 1'b1);
        bits("111");
        check_val("len0_clamp", 32'(bus.seq_out), 0);
        bits("1");
        check_val("len0_match", 32'(bus.seq_out), 1);

        // Gap of three invalid cycles inside a partial match.
        load(4'b1111, 4, 1'b1);
        bits("111");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        check_val("gap_hold", 32'(bus.seq_out), 0);
        bits("1");
        check_val("gap_match", 32'(bus.seq_out), 1);
        step(0, 0, 0, 0, 0);
        check_val("gap_out_holds", 32'(bus.seq_out), 1);
        // Load with a coincident valid bit: that bit is discarded.
        step(0, 1, 1, 1, 0, 4'b1111, 4, 1'b1);
        bits("111");
        check_val("load_discard", 32'(bus.seq_out), 0);
        bits("1");
        check_val("load_after", 32'(bus.seq_out), 1);

        // Reset mid-pattern.
        bits("0111");
        step(1, 0, 1, 1, 0);
        check_val("midrst_out", 32'(bus.seq_out), 0);
        check_val("midrst_cnt", 32'(bus.match_count), 0);
        bits("111");
        check_val("midrst_no", 32'(bus.seq_out), 0);
        bits("1");
        check_val("midrst_match", 32'(bus.seq_out), 1);

        // Saturation of the 2-bit counter, then clear coinciding with a match.
        load(4'b0001, 1, 1'b1);
        bits("11111");
        check_val("sat2", 32'(bus2.match_count), cexp(3));
        step(0, 0, 1, 1, 1);
        check_val("clr_match8", 32'(bus.match_count), cexp(1));
        check_val("clr_match2", 32'(bus2.match_count), cexp(1));
        step(0, 0, 1, 0, 1);
        check_val("clr_alone", 32'(bus.match_count), 0);

        // 8-bit counter saturation with a one-bit pattern.
        for (int i = 0; i < 260; i++) step(0, 0, 1, 1, 0);
        check_val("sat8", 32'(bus.match_count), cexp(255));

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2)
                step(1, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            else if (r < 6)
                step(0, 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 9) == 0,
                     PAT_W'($urandom), $urandom_range(0, 7), $urandom_range(0, 1));
            else
                step(0, 0, $urandom_range(0, 4) != 0, $urandom_range(0, 1), $urandom_range(0, 29) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
